// File: rtl/udp_pkg.sv
`default_nettype none
// == udp_pkg : shared types and helpers for the UDP port filter parser == rev 1.0 ==
package udp_pkg;
   localparam int UDP_HDR_BYTES = 8;

   typedef enum logic [1:0] {
      HDR     = 2'd0,
      EVAL    = 2'd1,
      PAYLOAD = 2'd2,
      DROP    = 2'd3
   } state_t;

   typedef struct packed {
      logic [15:0] src;
      logic [15:0] dst;
      logic [15:0] len;
      logic [15:0] csum;
   } udp_hdr_t;

   function automatic logic [15:0] bytes_in_beat(input logic [15:0] beat_bytes,
                                                 input logic [15:0] empty);
      return beat_bytes - empty;
   endfunction
endpackage
`default_nettype wire

// File: rtl/udp_port_match.sv
`default_nettype none
// == udp_port_match : dst-port comparator table with lowest-index priority == rev 1.0 ==
module udp_port_match #(
   parameter int NUM_PORTS = 4,
   parameter int IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
   input  logic [15:0]           dst,
   input  logic [16*NUM_PORTS-1:0] port_table,
   input  logic [NUM_PORTS-1:0]  enables,
   output logic                  match,
   output logic [IW-1:0]         idx
);
   // Scan from the top so the lowest matching index is the last writer.
   always_comb begin
      match = 1'b0;
      idx   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (enables[i] && (port_table[16*i +: 16] == dst)) begin
            match = 1'b1;
            idx   = IW'(i);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/udp_port_filter_parser.sv
`default_nettype none
// == udp_port_filter_parser : multi-byte UDP header parser with dst-port filter == rev 1.0 ==
module udp_port_filter_parser
   import udp_pkg::*;
#(
   parameter int BEAT_BYTES = 1,
   parameter int NUM_PORTS  = 4,
   parameter int CNT_W      = 16,
   localparam int EW = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1,
   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [8*BEAT_BYTES-1:0] in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic [EW-1:0]           in_empty,
   output logic                    in_ready,
   input  logic [16*NUM_PORTS-1:0] target_ports,
   input  logic [NUM_PORTS-1:0]    port_enable,
   output logic [15:0]             src_port,
   output logic [15:0]             dst_port,
   output logic [15:0]             length,
   output logic [15:0]             checksum,
   output logic                    hdr_valid,
   output logic                    port_match,
   output logic [IW-1:0]           match_idx,
   output logic [8*BEAT_BYTES-1:0] out_data,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [EW-1:0]           out_empty,
   input  logic                    out_ready,
   output logic                    pkt_done,
   output logic                    len_err,
   output logic                    trunc_err,
   output logic [CNT_W-1:0]        drop_count
);
   localparam int HB = UDP_HDR_BYTES / BEAT_BYTES;

   state_t      state;
   logic [63:0] hdr_sr;
   logic [63:0] hdr_next;
   logic [3:0]  beat_cnt;
   logic        end_seen;
   logic [15:0] pay_cnt;
   logic [15:0] beat_bytes;
   udp_hdr_t    hdr;
   logic        xfer;
   logic        m_hit;
   logic [IW-1:0] m_idx;

   assign hdr        = hdr_sr;
   assign hdr_next   = 64'({hdr_sr, in_data});
   assign beat_bytes = bytes_in_beat(16'(BEAT_BYTES), 16'(in_empty));
   assign xfer       = in_valid && in_ready;

   udp_port_match #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_match (
      .dst        (hdr.dst),
      .port_table (target_ports),
      .enables    (port_enable),
      .match      (m_hit),
      .idx        (m_idx)
   );

   // Payload is a zero-latency pass-through; everything else is gated off.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      out_empty = '0;
      case (state)
         HDR, DROP: in_ready = 1'b1;
         PAYLOAD: begin
            in_ready  = out_ready;
            out_valid = in_valid;
            out_last  = in_last;
            out_data  = in_data;
            out_empty = in_empty;
         end
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HDR;
         hdr_sr     <= '0;
         beat_cnt   <= '0;
         end_seen   <= 1'b0;
         pay_cnt    <= '0;
         src_port   <= '0;
         dst_port   <= '0;
         length     <= '0;
         checksum   <= '0;
         port_match <= 1'b0;
         match_idx  <= '0;
         hdr_valid  <= 1'b0;
         pkt_done   <= 1'b0;
         len_err    <= 1'b0;
         trunc_err  <= 1'b0;
         drop_count <= '0;
      end else begin
         hdr_valid <= 1'b0;
         pkt_done  <= 1'b0;
         len_err   <= 1'b0;
         trunc_err <= 1'b0;
         case (state)
            HDR: begin
               if (xfer) begin
                  hdr_sr <= hdr_next;
                  if (beat_cnt == 4'(HB - 1)) begin
                     state    <= EVAL;
                     end_seen <= in_last;
                     beat_cnt <= '0;
                  end else if (in_last) begin
                     pkt_done  <= 1'b1;
                     trunc_err <= 1'b1;
                     beat_cnt  <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end
            EVAL: begin
               src_port   <= hdr.src;
               dst_port   <= hdr.dst;
               length     <= hdr.len;
               checksum   <= hdr.csum;
               port_match <= m_hit;
               match_idx  <= m_idx;
               hdr_valid  <= 1'b1;
               pay_cnt    <= '0;
               if (hdr.len < 16'(UDP_HDR_BYTES)) begin
                  len_err <= 1'b1;
                  if (end_seen) begin
                     pkt_done <= 1'b1;
                     state    <= HDR;
                  end else begin
                     state <= DROP;
                  end
               end else if (end_seen) begin
                  pkt_done <= 1'b1;
                  len_err  <= (hdr.len != 16'(UDP_HDR_BYTES));
                  state    <= HDR;
               end else if (m_hit) begin
                  state <= PAYLOAD;
               end else begin
                  state <= DROP;
                  if (drop_count != {CNT_W{1'b1}})
                     drop_count <= drop_count + CNT_W'(1);
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  pay_cnt <= pay_cnt + beat_bytes;
                  if (in_last) begin
                     state    <= HDR;
                     pkt_done <= 1'b1;
                     len_err  <= ((16'(UDP_HDR_BYTES) + pay_cnt + beat_bytes) != length);
                  end
               end
            end
            DROP: begin
               if (xfer && in_last) begin
                  state    <= HDR;
                  pkt_done <= 1'b1;
               end
            end
            default: state <= HDR;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_udp_port_filter_parser.sv
`default_nettype none
// == tb_udp_port_filter_parser : directed bench for 1-byte and 4-byte beat configs == rev 1.0 ==
module tb_udp_port_filter_parser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int asserts = 0;
   int fails   = 0;

   // ---- instance A: BEAT_BYTES=1 ----
   logic [7:0]  a_data = '0;
   logic        a_valid = 1'b0, a_last = 1'b0, a_ready;
   logic [0:0]  a_empty = '0;
   logic [63:0] a_tp = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
   logic [3:0]  a_en = 4'b0001;
   logic [15:0] a_src, a_dst, a_len, a_csum, a_dc;
   logic        a_hv, a_pm, a_ovalid, a_olast, a_oready, a_pd, a_le, a_te;
   logic [1:0]  a_midx;
   logic [7:0]  a_odata;
   logic [0:0]  a_oempty;
   logic        a_tog = 1'b0;

   udp_port_filter_parser #(.BEAT_BYTES(1), .NUM_PORTS(4), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
      .in_empty(a_empty), .in_ready(a_ready), .target_ports(a_tp), .port_enable(a_en),
      .src_port(a_src), .dst_port(a_dst), .length(a_len), .checksum(a_csum),
      .hdr_valid(a_hv), .port_match(a_pm), .match_idx(a_midx), .out_data(a_odata),
      .out_valid(a_ovalid), .out_last(a_olast), .out_empty(a_oempty), .out_ready(a_oready),
      .pkt_done(a_pd), .len_err(a_le), .trunc_err(a_te), .drop_count(a_dc));

   // ---- instance B: BEAT_BYTES=4, 2-bit drop counter ----
   logic [31:0] b_data = '0;
   logic        b_valid = 1'b0, b_last = 1'b0, b_ready;
   logic [1:0]  b_empty = '0;
   logic [63:0] b_tp = {16'h2222, 16'h0050, 16'h0050, 16'h1111};
   logic [3:0]  b_en = 4'b1101;
   logic [15:0] b_src, b_dst, b_len, b_csum;
   logic [1:0]  b_dc, b_midx, b_oempty;
   logic        b_hv, b_pm, b_ovalid, b_olast, b_pd, b_le, b_te;
   logic        b_oready = 1'b1;
   logic [31:0] b_odata;

   udp_port_filter_parser #(.BEAT_BYTES(4), .NUM_PORTS(4), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
      .in_empty(b_empty), .in_ready(b_ready), .target_ports(b_tp), .port_enable(b_en),
      .src_port(b_src), .dst_port(b_dst), .length(b_len), .checksum(b_csum),
      .hdr_valid(b_hv), .port_match(b_pm), .match_idx(b_midx), .out_data(b_odata),
      .out_valid(b_ovalid), .out_last(b_olast), .out_empty(b_oempty), .out_ready(b_oready),
      .pkt_done(b_pd), .len_err(b_le), .trunc_err(b_te), .drop_count(b_dc));

   // out_ready for A: held high, or toggled every cycle while a_tog is set
   initial begin
      a_oready = 1'b1;
      forever begin
         @(posedge clk); #1;
         a_oready = a_tog ? ~a_oready : 1'b1;
      end
   end

   // Negedge monitors: record accepted output beats and count pulses
   int a_hv_n = 0, a_le_n = 0, a_ov_n = 0, a_nr_n = 0, a_mir_n = 0, a_stall_n = 0;
   logic [7:0]  a_q[$];
   logic        a_lq[$];
   logic [31:0] b_q[$];
   logic        b_lq[$];
   logic [1:0]  b_eq[$];
   always @(negedge clk) begin
      if (a_hv) a_hv_n++;
      if (a_le) a_le_n++;
      if (a_ovalid) a_ov_n++;
      if (a_valid && !a_ready) a_nr_n++;
      if (a_ovalid && (a_ready !== a_oready)) a_mir_n++;
      if (a_ovalid && !a_oready) a_stall_n++;
      if (a_ovalid && a_oready) begin a_q.push_back(a_odata); a_lq.push_back(a_olast); end
      if (b_ovalid && b_oready) begin b_q.push_back(b_odata); b_lq.push_back(b_olast); b_eq.push_back(b_oempty); end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive1(input logic [7:0] d, input logic l);
      int t;
      t = 0;
      a_data = d; a_valid = 1'b1; a_last = l;
      @(negedge clk);
      while (!a_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin asserts++; fails++; $display("FAIL drive1_timeout: in_ready stuck at %b, want 1", a_ready); end
      @(posedge clk); #1;
      a_valid = 1'b0; a_last = 1'b0;
   endtask

   task automatic drive4(input logic [31:0] d, input logic l, input logic [1:0] e);
      int t;
      t = 0;
      b_data = d; b_valid = 1'b1; b_last = l; b_empty = e;
      @(negedge clk);
      while (!b_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin asserts++; fails++; $display("FAIL drive4_timeout: in_ready stuck at %b, want 1", b_ready); end
      @(posedge clk); #1;
      b_valid = 1'b0; b_last = 1'b0; b_empty = '0;
   endtask

   task automatic send_dgram1(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                              input logic [15:0] c, input int npay, input logic [7:0] base);
      logic [63:0] h;
      h = {s, d, l, c};
      for (int i = 0; i < 8; i++) drive1(h[63-8*i -: 8], (npay == 0) && (i == 7));
      for (int i = 0; i < npay; i++) drive1(base + 8'(i), i == npay - 1);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      asserts++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
      asserts++; if ({a_src, a_dst, a_len, a_csum} !== 64'h0) begin fails++; $display("FAIL reset_a_fields: got %h want 0", {a_src, a_dst, a_len, a_csum}); end
      asserts++; if ({a_hv, a_pm, a_midx, a_ovalid, a_olast, a_pd, a_le, a_te} !== 9'h0) begin fails++; $display("FAIL reset_a_flags: got %b want 0", {a_hv, a_pm, a_midx, a_ovalid, a_olast, a_pd, a_le, a_te}); end
      asserts++; if (a_dc !== 16'h0) begin fails++; $display("FAIL reset_a_dc: got %h want 0", a_dc); end
      asserts++; if (b_ready !== 1'b1 || b_dc !== 2'd0 || b_odata !== 32'h0) begin fails++; $display("FAIL reset_b: ready %b dc %h odata %h want 1 0 0", b_ready, b_dc, b_odata); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      asserts++; if (a_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", a_ready); end
   endtask

   task automatic test_basic();
      logic [63:0] h;
      logic [7:0]  p[4];
      int q0;
      h = 64'hABCD_1234_000C_BEEF;
      p = '{8'h11, 8'h22, 8'h33, 8'h44};
      q0 = a_q.size();
      for (int i = 0; i < 8; i++) drive1(h[63-8*i -: 8], 1'b0);
      asserts++; if (a_hv !== 1'b0) begin fails++; $display("FAIL basic_hv_early: got %b want 0", a_hv); end
      @(posedge clk); #1;
      asserts++; if (a_hv !== 1'b1) begin fails++; $display("FAIL basic_hv: got %b want 1", a_hv); end
      asserts++; if ({a_src, a_dst, a_len, a_csum} !== 64'hABCD_1234_000C_BEEF) begin fails++; $display("FAIL basic_fields: got %h want abcd1234000cbeef", {a_src, a_dst, a_len, a_csum}); end
      asserts++; if (a_pm !== 1'b1 || a_midx !== 2'd0) begin fails++; $display("FAIL basic_match: got pm %b idx %0d want 1 0", a_pm, a_midx); end
      for (int i = 0; i < 4; i++) drive1(p[i], i == 3);
      asserts++; if ({a_pd, a_le, a_te} !== 3'b100) begin fails++; $display("FAIL basic_done: got pd/le/te %b want 100", {a_pd, a_le, a_te}); end
      asserts++; if (a_q.size() - q0 != 4) begin fails++; $display("FAIL basic_count: got %0d beats want 4", a_q.size() - q0); end
      else for (int i = 0; i < 4; i++) begin
         asserts++; if (a_q[q0+i] !== p[i] || a_lq[q0+i] !== (i == 3)) begin fails++; $display("FAIL basic_beat%0d: got %h last %b want %h last %b", i, a_q[q0+i], a_lq[q0+i], p[i], i == 3); end
      end
   endtask

   task automatic test_trunc();
      int hv0;
      hv0 = a_hv_n;
      for (int i = 0; i < 5; i++) drive1(8'(i + 1), i == 4);
      asserts++; if ({a_pd, a_te, a_le} !== 3'b110) begin fails++; $display("FAIL trunc_pulse: got pd/te/le %b want 110", {a_pd, a_te, a_le}); end
      repeat (2) @(posedge clk);
      #1;
      asserts++; if (a_hv_n != hv0) begin fails++; $display("FAIL trunc_no_hv: got %0d hdr_valid want 0", a_hv_n - hv0); end
      send_dgram1(16'h0101, 16'h1234, 16'd10, 16'h7777, 2, 8'hC0);
      asserts++; if ({a_src, a_dst, a_len, a_csum} !== 64'h0101_1234_000A_7777) begin fails++; $display("FAIL trunc_next_fields: got %h want 01011234000a7777", {a_src, a_dst, a_len, a_csum}); end
      asserts++; if ({a_pd, a_le, a_te} !== 3'b100) begin fails++; $display("FAIL trunc_next_done: got %b want 100", {a_pd, a_le, a_te}); end
   endtask

   task automatic test_drop();
      int ov0, nr0;
      ov0 = a_ov_n; nr0 = a_nr_n;
      send_dgram1(16'h4444, 16'h9999, 16'd28, 16'h0000, 20, 8'h00);
      asserts++; if (a_pd !== 1'b1) begin fails++; $display("FAIL drop_done: got %b want 1", a_pd); end
      asserts++; if (a_dc !== 16'd1) begin fails++; $display("FAIL drop_count: got %0d want 1", a_dc); end
      asserts++; if (a_ov_n != ov0) begin fails++; $display("FAIL drop_no_out: got %0d out_valid cycles want 0", a_ov_n - ov0); end
      asserts++; if (a_nr_n - nr0 != 1) begin fails++; $display("FAIL drop_ready: got %0d stalled cycles want 1", a_nr_n - nr0); end
      asserts++; if (a_pm !== 1'b0 || a_midx !== 2'd0) begin fails++; $display("FAIL drop_match: got pm %b idx %0d want 0 0", a_pm, a_midx); end
   endtask

   task automatic test_len_err();
      int le0, ov0, q0;
      le0 = a_le_n; ov0 = a_ov_n;
      send_dgram1(16'h0001, 16'h1234, 16'd4, 16'h0000, 4, 8'h50);
      asserts++; if (a_le_n - le0 != 1) begin fails++; $display("FAIL short_len_err: got %0d pulses want 1", a_le_n - le0); end
      asserts++; if (a_ov_n != ov0) begin fails++; $display("FAIL short_no_out: got %0d out_valid cycles want 0", a_ov_n - ov0); end
      asserts++; if (a_pd !== 1'b1) begin fails++; $display("FAIL short_done: got %b want 1", a_pd); end
      q0 = a_q.size();
      send_dgram1(16'h0002, 16'h1234, 16'd16, 16'h0000, 4, 8'h60);
      asserts++; if ({a_pd, a_le} !== 2'b11) begin fails++; $display("FAIL long_len_err: got pd/le %b want 11", {a_pd, a_le}); end
      asserts++; if (a_q.size() - q0 != 4) begin fails++; $display("FAIL long_fwd: got %0d beats want 4", a_q.size() - q0); end
   endtask

   task automatic test_backpressure();
      int q0, mir0, st0;
      q0 = a_q.size(); mir0 = a_mir_n; st0 = a_stall_n;
      a_tog = 1'b1;
      send_dgram1(16'h0003, 16'h1234, 16'd14, 16'h0000, 6, 8'hA0);
      a_tog = 1'b0;
      asserts++; if ({a_pd, a_le} !== 2'b10) begin fails++; $display("FAIL bp_done: got pd/le %b want 10", {a_pd, a_le}); end
      asserts++; if (a_mir_n != mir0) begin fails++; $display("FAIL bp_mirror: got %0d cycles in_ready!=out_ready want 0", a_mir_n - mir0); end
      asserts++; if (a_stall_n == st0) begin fails++; $display("FAIL bp_stalled: got %0d stall cycles want >0", a_stall_n - st0); end
      asserts++; if (a_q.size() - q0 != 6) begin fails++; $display("FAIL bp_count: got %0d beats want 6", a_q.size() - q0); end
      else for (int i = 0; i < 6; i++) begin
         asserts++; if (a_q[q0+i] !== 8'hA0 + 8'(i) || a_lq[q0+i] !== (i == 5)) begin fails++; $display("FAIL bp_beat%0d: got %h last %b want %h last %b", i, a_q[q0+i], a_lq[q0+i], 8'hA0 + 8'(i), i == 5); end
      end
   endtask

   task automatic test_multibeat();
      int q0;
      logic [31:0] p[3];
      p = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0000};
      q0 = b_q.size();
      drive4(32'h0A0B_0050, 1'b0, 2'd0);
      drive4(32'h0012_5555, 1'b0, 2'd0);
      for (int i = 0; i < 3; i++) drive4(p[i], i == 2, (i == 2) ? 2'd2 : 2'd0);
      asserts++; if (b_pm !== 1'b1 || b_midx !== 2'd2) begin fails++; $display("FAIL mb_match: got pm %b idx %0d want 1 2", b_pm, b_midx); end
      asserts++; if ({b_src, b_dst, b_len, b_csum} !== 64'h0A0B_0050_0012_5555) begin fails++; $display("FAIL mb_fields: got %h want 0a0b005000125555", {b_src, b_dst, b_len, b_csum}); end
      asserts++; if ({b_pd, b_le, b_te} !== 3'b100) begin fails++; $display("FAIL mb_done: got pd/le/te %b want 100", {b_pd, b_le, b_te}); end
      asserts++; if (b_q.size() - q0 != 3) begin fails++; $display("FAIL mb_count: got %0d beats want 3", b_q.size() - q0); end
      else for (int i = 0; i < 3; i++) begin
         asserts++; if (b_q[q0+i] !== p[i] || b_lq[q0+i] !== (i == 2) || b_eq[q0+i] !== ((i == 2) ? 2'd2 : 2'd0)) begin
            fails++; $display("FAIL mb_beat%0d: got %h last %b empty %0d want %h last %b empty %0d", i, b_q[q0+i], b_lq[q0+i], b_eq[q0+i], p[i], i == 2, (i == 2) ? 2 : 0); end
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_dc[4];
      exp_dc = '{2'd1, 2'd2, 2'd3, 2'd3};
      for (int k = 0; k < 4; k++) begin
         b_en = (k == 0) ? 4'b0000 : 4'b1101;
         drive4((k == 0) ? 32'h0001_1111 : 32'h0001_9999, 1'b0, 2'd0);
         drive4(32'h000C_0000, 1'b0, 2'd0);
         drive4(32'hDEAD_BEEF, 1'b1, 2'd0);
         asserts++; if (b_pm !== 1'b0 || b_pd !== 1'b1) begin fails++; $display("FAIL sat_drop%0d: got pm %b pd %b want 0 1", k, b_pm, b_pd); end
         asserts++; if (b_dc !== exp_dc[k]) begin fails++; $display("FAIL sat_count%0d: got %0d want %0d", k, b_dc, exp_dc[k]); end
      end
      b_en = 4'b1101;
   endtask

   task automatic test_reset_mid();
      logic [63:0] h;
      h = 64'h1111_1234_0014_2222;
      for (int i = 0; i < 8; i++) drive1(h[63-8*i -: 8], 1'b0);
      drive1(8'h01, 1'b0);
      drive1(8'h02, 1'b0);
      a_data = 8'h99; a_valid = 1'b1;
      rst_n = 1'b0;
      #2;
      asserts++; if (a_ovalid !== 1'b0 || a_odata !== 8'h00 || a_ready !== 1'b1) begin fails++; $display("FAIL rstmid_out: got ov %b od %h rdy %b want 0 00 1", a_ovalid, a_odata, a_ready); end
      asserts++; if ({a_src, a_dst, a_len, a_csum} !== 64'h0 || a_pm !== 1'b0 || a_dc !== 16'h0 || b_dc !== 2'd0) begin fails++; $display("FAIL rstmid_regs: got %h pm %b dc %h/%h want 0", {a_src, a_dst, a_len, a_csum}, a_pm, a_dc, b_dc); end
      a_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send_dgram1(16'h5A5A, 16'h1234, 16'd9, 16'hC3C3, 1, 8'h77);
      asserts++; if ({a_src, a_dst, a_len, a_csum} !== 64'h5A5A_1234_0009_C3C3) begin fails++; $display("FAIL rstmid_next: got %h want 5a5a12340009c3c3", {a_src, a_dst, a_len, a_csum}); end
      asserts++; if ({a_pd, a_le, a_te} !== 3'b100) begin fails++; $display("FAIL rstmid_done: got %b want 100", {a_pd, a_le, a_te}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_trunc();
      test_drop();
      test_len_err();
      test_backpressure();
      test_multibeat();
      test_saturate();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
`default_nettype wire
